// File: rtl/uart_frame_decoder.sv
// Store-and-forward SOF/LEN/payload/CSUM frame parser; payload is released only after the checksum verifies.
// First out_valid appears 1 cycle after the CSUM accept; input stalls while a verified frame drains under out_ready backpressure.
module uart_frame_decoder #(
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_bits,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_bits,
    output logic       out_last,
    output logic       err_pulse,
    output logic [1:0] err_code,
    output logic [7:0] frame_count
);

    localparam int          IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  SOF       = 8'h7E;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [17:0] TIMEOUT_W = 18'(TIMEOUT);

    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_LEN     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_DRAIN
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [7:0]      len_q;
    logic [7:0]      sum_q;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   rd_q;
    logic [17:0]     timer_q;
    logic [7:0]      mem [MAX_LEN];

    logic            accept;
    logic            xfer;
    logic            in_frame;
    logic            timed_out;
    logic            len_bad;
    logic            last_payload;
    logic            last_rd;
    logic [7:0]      csum_total;
    logic            csum_ok;
    logic            abort;
    logic [1:0]      abort_code;

    assign accept       = in_valid & in_ready;
    assign xfer         = out_valid & out_ready;
    assign in_frame     = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
    // An accept in the same cycle always beats the timeout.
    assign timed_out    = in_frame && !accept && (timer_q >= TIMEOUT_W);
    assign len_bad      = (in_bits == 8'h00) || (in_bits > MAX_LEN_B);
    assign last_payload = (8'(idx_q) == (len_q - 8'd1));
    assign last_rd      = (8'(rd_q) == (len_q - 8'd1));
    assign csum_total   = sum_q + in_bits;
    assign csum_ok      = (csum_total == 8'h00);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and abort decode
    always_comb begin
        state_nxt  = state;
        abort      = 1'b0;
        abort_code = 2'b00;
        case (state)
            S_HUNT: begin
                if (accept && (in_bits == SOF)) begin
                    state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (accept) begin
                    if (len_bad) begin
                        state_nxt  = S_HUNT;
                        abort      = 1'b1;
                        abort_code = ERR_LEN;
                    end else begin
                        state_nxt = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (accept && last_payload) begin
                    state_nxt = S_CSUM;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (csum_ok) begin
                        state_nxt = S_DRAIN;
                    end else begin
                        state_nxt  = S_HUNT;
                        abort      = 1'b1;
                        abort_code = ERR_CSUM;
                    end
                end
            end
            S_DRAIN: begin
                if (xfer && last_rd) begin
                    state_nxt = S_HUNT;
                end
            end
            default: begin
                state_nxt = S_HUNT;
            end
        endcase
        if (timed_out) begin
            state_nxt  = S_HUNT;
            abort      = 1'b1;
            abort_code = ERR_TIMEOUT;
        end
    end

    // Outputs decoded from state
    always_comb begin
        in_ready  = (state != S_DRAIN);
        out_valid = (state == S_DRAIN);
        out_bits  = 8'h00;
        out_last  = 1'b0;
        if (state == S_DRAIN) begin
            out_bits = mem[rd_q];
            out_last = last_rd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q       <= 8'h00;
            sum_q       <= 8'h00;
            idx_q       <= '0;
            rd_q        <= '0;
            timer_q     <= 18'd0;
            err_pulse   <= 1'b0;
            err_code    <= 2'b00;
            frame_count <= 8'h00;
        end else begin
            err_pulse <= abort;
            if (abort) begin
                err_code <= abort_code;
            end

            if (accept || abort || !in_frame) begin
                timer_q <= 18'd0;
            end else begin
                timer_q <= timer_q + 18'd1;
            end

            if ((state == S_LEN) && accept && !len_bad) begin
                len_q <= in_bits;
                sum_q <= in_bits;
                idx_q <= '0;
            end

            if ((state == S_PAYLOAD) && accept) begin
                sum_q <= sum_q + in_bits;
                idx_q <= idx_q + 1'b1;
            end

            if ((state == S_CSUM) && accept && csum_ok) begin
                rd_q <= '0;
            end

            if ((state == S_DRAIN) && xfer) begin
                rd_q <= rd_q + 1'b1;
                if (last_rd) begin
                    frame_count <= frame_count + 8'd1;
                end
            end
        end
    end

    // Payload buffer has no reset; only entries below len_q are ever read.
    always_ff @(posedge clk) begin
        if ((state == S_PAYLOAD) && accept) begin
            mem[idx_q] <= in_bits;
        end
    end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed-vector bench for uart_frame_decoder with a queue scoreboard and an independent output monitor.
module tb_uart_frame_decoder;

    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 40;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_bits;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_bits;
    logic       out_last;
    logic       err_pulse;
    logic [1:0] err_code;
    logic [7:0] frame_count;

    uart_frame_decoder #(
        .MAX_LEN(MAX_LEN),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bits    (in_bits),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bits   (out_bits),
        .out_last   (out_last),
        .err_pulse  (err_pulse),
        .err_code   (err_code),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_mis = 0;
    int         exp_fc = 0;
    logic [8:0] exp_q[$];   // {last, bits}
    logic [1:0] err_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL unexpected_out: got bits %0h last %0b, expected no output", out_bits, out_last);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("out_bits", {24'h0, out_bits}, {24'h0, e[7:0]});
                    chk("out_last", {31'h0, out_last}, {31'h0, e[8]});
                end
            end
            if (!out_valid) begin
                chk("idle_out_zero", {23'h0, out_last, out_bits}, 32'h0);
            end
            if (err_pulse) begin
                if (err_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL unexpected_err: got code %0b, expected no error pulse", err_code);
                end else begin
                    logic [1:0] ec;
                    ec = err_q.pop_front();
                    chk("err_code", {30'h0, err_code}, {30'h0, ec});
                end
            end
        end
    end

    // Driver is always parked at posedge+1 between calls.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_bits  = b;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_bound", {31'h0, in_ready}, 32'h1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bits  = 8'h00;
    endtask

    task automatic send_err(input logic [7:0] b, input logic [1:0] code);
        err_q.push_back(code);
        send_byte(b);
        @(negedge clk);
        chk("err_pulse_timing", {31'h0, err_pulse}, 32'h1);
        @(posedge clk);
        #1;
    endtask

    // Sends a full frame expected to verify; returns at the negedge after the CSUM accept.
    task automatic send_frame(input logic [7:0] pl[$], input logic [7:0] cs);
        for (int i = 0; i < pl.size(); i++) begin
            exp_q.push_back({(i == pl.size() - 1), pl[i]});
        end
        send_byte(8'h7E);
        send_byte(8'(pl.size()));
        for (int i = 0; i < pl.size(); i++) begin
            send_byte(pl[i]);
        end
        send_byte(cs);
        @(negedge clk);
        chk("first_out_valid", {31'h0, out_valid}, 32'h1);
        chk("first_out_bits", {24'h0, out_bits}, {24'h0, pl[0]});
    endtask

    task automatic drain_wait(input int exp_cycles);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (exp_q.size() != 0 && n < 100);
        #1;
        chk("drain_done", exp_q.size(), 32'h0);
        chk("drain_cycles", n, exp_cycles);
        exp_fc++;
        chk("frame_count", {24'h0, frame_count}, 32'(exp_fc & 8'hFF));
        chk("in_ready_after", {31'h0, in_ready}, 32'h1);
        chk("out_valid_after", {31'h0, out_valid}, 32'h0);
    endtask

    initial begin
        logic [7:0] pl[$];
        int n;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_bits   = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_err_pulse", {31'h0, err_pulse}, 32'h0);
        chk("rst_err_code", {30'h0, err_code}, 32'h0);
        chk("rst_frame_count", {24'h0, frame_count}, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Good frame: 03+11+22+33 = 69, 69+97 = 00
        pl = {8'h11, 8'h22, 8'h33};
        send_frame(pl, 8'h97);
        drain_wait(3);

        // Bad checksum, then a clean frame proves resync
        send_byte(8'h7E);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_err(8'h98, 2'b01);
        chk("csum_fc_unchanged", {24'h0, frame_count}, 32'(exp_fc));
        pl = {8'h5A};
        send_frame(pl, 8'hA5);
        drain_wait(1);

        // Bad lengths: zero and MAX_LEN+1, trailing bytes discarded
        send_byte(8'h7E);
        send_err(8'h00, 2'b10);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h7E);
        send_err(8'h11, 2'b10);
        send_byte(8'h33);
        send_byte(8'h44);
        chk("badlen_err_code", {30'h0, err_code}, 32'h2);

        // Leading garbage; second 7E is a length and aborts
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h7E);
        send_err(8'h7E, 2'b10);
        send_byte(8'h01);
        send_byte(8'h5A);
        send_byte(8'hA5);
        pl = {8'h5A};
        send_frame(pl, 8'hA5);
        drain_wait(1);

        // Maximum length: 10 + (0+..+F = 78) = 88, 88+78 = 00
        pl = {};
        for (int i = 0; i < MAX_LEN; i++) begin
            pl.push_back(8'(i));
        end
        send_frame(pl, 8'h78);
        drain_wait(MAX_LEN);

        // Backpressure: 02+AB+CD = 7A, 7A+86 = 00
        out_ready = 1'b0;
        pl = {8'hAB, 8'hCD};
        send_frame(pl, 8'h86);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
            chk("bp_out_bits", {24'h0, out_bits}, 32'hAB);
            chk("bp_out_last", {31'h0, out_last}, 32'h0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain_wait(2);

        // Timeout mid-payload
        err_q.push_back(2'b11);
        send_byte(8'h7E);
        send_byte(8'h02);
        send_byte(8'h11);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!err_pulse && n < TIMEOUT + 20);
        chk("timeout_fired", {31'h0, err_pulse}, 32'h1);
        chk("timeout_not_early", {31'h0, (n >= TIMEOUT)}, 32'h1);
        chk("timeout_not_late", {31'h0, (n <= TIMEOUT + 3)}, 32'h1);
        @(posedge clk);
        #1;
        pl = {8'h5A};
        send_frame(pl, 8'hA5);
        drain_wait(1);

        // Reset mid-drain
        out_ready = 1'b0;
        pl = {8'h5A};
        send_frame(pl, 8'hA5);
        @(posedge clk);
        #1;
        exp_q.delete();
        reset = 1'b0;
        #1;
        chk("rst_drain_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_drain_fc", {24'h0, frame_count}, 32'h0);
        chk("rst_drain_in_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        exp_fc    = 0;
        @(posedge clk);
        #1;
        pl = {8'h5A};
        send_frame(pl, 8'hA5);
        drain_wait(1);

        repeat (3) @(posedge clk);
        #1;
        chk("exp_q_empty", exp_q.size(), 32'h0);
        chk("err_q_empty", err_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
